// File: rtl/alu_share_arbiter_if.sv
// Core-side bus of the shared ALU arbiter: per-core requests and operands,
// plus the grant/done strobes and the shared registered result.
interface alu_share_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 32
);
    logic [NUM_CORES-1:0]        req;
    logic [3*NUM_CORES-1:0]      op_in;
    logic [DATA_W*NUM_CORES-1:0] a_in;
    logic [DATA_W*NUM_CORES-1:0] b_in;
    logic [NUM_CORES-1:0]        gnt;
    logic [NUM_CORES-1:0]        done;
    logic [DATA_W-1:0]           result;
    logic                        zero;
    logic                        err;
    logic                        busy;

    modport master (
        output req, op_in, a_in, b_in,
        input  gnt, done, result, zero, err, busy
    );

    modport slave (
        input  req, op_in, a_in, b_in,
        output gnt, done, result, zero, err, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_CORES cores.
// Each operation takes IDLE (select) -> EXEC (ALU settles) -> DONE (result pulse).
module alu_share_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_share_arbiter_if.slave bus,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_z
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [2:0] OP_DIV = 3'd4;
    localparam logic [2:0] OP_MOD = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_win;
    logic                 r_dz;
    logic [NUM_CORES-1:0] r_gnt;
    logic [NUM_CORES-1:0] r_done;
    logic [DATA_W-1:0]    r_result;
    logic                 r_zero;
    logic                 r_err;
    logic [2:0]           r_alu_op;
    logic [DATA_W-1:0]    r_alu_a;
    logic [DATA_W-1:0]    r_alu_b;

    logic [PTR_W:0]       w_pick;
    logic                 w_found;
    logic [PTR_W-1:0]     w_win;
    logic [2:0]           w_op;
    logic [DATA_W-1:0]    w_a;
    logic [DATA_W-1:0]    w_b;
    logic                 w_dz;

    // First requester at or above ptr, wrapping; returns {found, index}.
    function automatic logic [PTR_W:0] pick_winner(
        input logic [NUM_CORES-1:0] rq,
        input logic [PTR_W-1:0]     ptr
    );
        logic             found;
        logic [PTR_W-1:0] idx;
        int               j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            j = (int'(ptr) + k) % NUM_CORES;
            if (!found && rq[j]) begin
                found = 1'b1;
                idx   = PTR_W'(j);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] win);
        if (win == PTR_W'(NUM_CORES - 1)) begin
            return '0;
        end
        return win + 1'b1;
    endfunction

    assign w_pick  = pick_winner(bus.req, r_ptr);
    assign w_found = w_pick[PTR_W];
    assign w_win   = w_pick[PTR_W-1:0];
    assign w_op    = bus.op_in[3*w_win +: 3];
    assign w_a     = bus.a_in[DATA_W*w_win +: DATA_W];
    assign w_b     = bus.b_in[DATA_W*w_win +: DATA_W];
    assign w_dz    = ((w_op == OP_DIV) || (w_op == OP_MOD)) && (w_b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_EXEC;
            S_EXEC:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            r_win    <= '0;
            r_dz     <= 1'b0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
            r_alu_op <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_win <= w_win;
                        r_dz  <= w_dz;
                        r_gnt <= {{(NUM_CORES-1){1'b0}}, 1'b1} << w_win;
                        // A zero divisor never reaches the ALU, so it cannot produce X.
                        if (w_dz) begin
                            r_alu_op <= '0;
                            r_alu_a  <= '0;
                            r_alu_b  <= '0;
                        end else begin
                            r_alu_op <= w_op;
                            r_alu_a  <= w_a;
                            r_alu_b  <= w_b;
                        end
                    end
                end
                S_EXEC: begin
                    r_done <= r_gnt;
                    if (r_dz) begin
                        r_result <= '0;
                        r_zero   <= 1'b0;
                        r_err    <= 1'b1;
                    end else begin
                        r_result <= alu_c;
                        r_zero   <= alu_z;
                        r_err    <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_done <= '0;
                    r_gnt  <= '0;
                    r_err  <= 1'b0;
                    r_ptr  <= next_ptr(r_win);
                end
                default: begin
                    r_done <= '0;
                    r_gnt  <= '0;
                end
            endcase
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.zero   = r_zero;
    assign bus.err    = r_err;
    assign bus.busy   = (r_state != S_IDLE);
    assign alu_op     = r_alu_op;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU between NUM_CORES requesting cores in the multi-core processor.
- Uses round-robin arbitration.
- Registers the winning core's opcode and operands onto the ALU inputs, then captures C_bus/Z one cycle later.
- Returns the registered result to the winner with a one-cycle done pulse. Guards DIV/MOD against a zero divisor.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8)
- DATA_W, 32, operand/result width; must match the ALU (32)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_CORES  per-core level request; held high until that core's done
- op_in  in  3*NUM_CORES  per-core opcode; core i occupies bits [3i+2:3i]
- a_in  in  DATA_W*NUM_CORES  per-core operand A; core i occupies [DATA_W*i +: DATA_W]
- b_in  in  DATA_W*NUM_CORES  per-core operand B, same packing as a_in
- gnt  out  NUM_CORES  one-hot; high while the core's operation occupies the ALU
- done  out  NUM_CORES  one-hot, one-cycle pulse; result/zero/err valid this cycle
- result  out  DATA_W  registered ALU result, shared by all cores
- zero  out  1  registered ALU Z flag
- err  out  1  high with done when a DIV/MOD had B==0
- busy  out  1  high whenever state != IDLE
- alu_op  out  3  to ALU op
- alu_a  out  DATA_W  to ALU A_bus
- alu_b  out  DATA_W  to ALU B_bus
- alu_c  in  DATA_W  from ALU C_bus
- alu_z  in  1  from ALU Z

Behaviour:
- Opcodes: ADD=1, SUB=2, MUL=3, DIV=4, MOD=5; other values pass through unchanged (ALU default).
- Reset: all outputs 0, including gnt, done, result, zero, err, busy, alu_op, alu_a and alu_b. State = IDLE, rr pointer = 0.
- FSM states: IDLE -> EXEC -> DONE -> IDLE.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise select the winner: the first i with req[i]=1, searching from ptr upward with wrap at NUM_CORES-1 -> 0.
  - At the clock edge, register op_in/a_in/b_in of the winner into alu_op/alu_a/alu_b, set gnt[winner], go to EXEC.
- EXEC (exactly 1 cycle):
  - ALU inputs are stable from registers; alu_c/alu_z settle combinationally.
  - At the edge: result<=alu_c, zero<=alu_z, err<=0, done[winner]<=1, gnt held. Go to DONE.
- Divide-by-zero guard:
  - Applies when the winner's op is DIV or MOD and b==0, evaluated in IDLE at selection.
  - Register alu_op=0 and alu_a=alu_b=0 instead of the core's values, so no X from the ALU.
  - In EXEC capture result=0, zero=0, err=1.
- DONE (1 cycle):
  - done pulse is visible; gnt still high.
  - At the edge: done<=0, gnt<=0, err<=0, ptr<=(winner+1) mod NUM_CORES, go to IDLE.
  - result/zero hold until the next capture. alu_op/alu_a/alu_b hold their last values.
- Latency: req sampled in IDLE at cycle 0 -> done high in cycle 2. Throughput is one operation per 3 cycles.
- Requester contract: deassert req at the edge ending the done cycle. If req is still high in the following IDLE, it is a new request.
- Changes on req/op_in/a_in/b_in of any core during EXEC/DONE are ignored. Deasserting req mid-operation does not cancel it; done is still issued.
- Simultaneous requests: exactly one winner per arbitration. A core that just completed has the lowest priority next round, so no core waits more than NUM_CORES-1 operations.
- Reset mid-operation (any state): immediate return to reset values; no done is issued for the aborted operation.
- SUB zero flag: passed through from the ALU unmodified. zero=1 when the ALU reports C<=0 signed.

Test Plan:
- Single request: core1 req, ADD a=7 b=5 -> gnt=4'b0010 in cycles 1-2, done[1] pulse in cycle 2, result=12, zero=0, err=0, busy high cycles 1-2.
- All four cores request simultaneously and re-request after each done, ptr=0 -> grant order 0,1,2,3,0; each done is 3 cycles apart; core2 DIV 100/7 returns 14, core3 MOD 100/7 returns 2.
- Divide-by-zero: core0 DIV a=9 b=0 -> alu_a=alu_b=0, alu_op=0 during EXEC; done[0] with result=0, err=1. Repeat with MOD b=0 -> same response.
- SUB flags: a=3 b=3 -> result=0, zero=1. a=2 b=5 -> result=0xFFFFFFFD, zero=1. a=5 b=2 -> result=3, zero=0.
- Reset mid-op: assert rst_n=0 during EXEC -> gnt, busy and done go to 0 immediately with no done pulse; after release, ptr=0 and a pending req[2] is granted first.
- Operand change and req drop during EXEC: core0 MUL 6*7, then change a_in and drop req in EXEC -> result=42, done[0] still issued.
